pcm_sample_fifo: RTL and testbench
==================================

Name: pcm_sample_fifo

Overview:
- Downstream stage of the 512-tap symmetric FIR decimator. Captures each 16-bit filtered sample presented with a one-cycle Push strobe and buffers it in a small FIFO.
- Delivers samples to the consumer over a valid/ready handshake, decoupling the FIR's bursty output from a back-pressuring sink.
- Tracks occupancy and counts dropped samples on overflow.

Parameters:
- WIDTH, 16, sample width; matches FIR Dout.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- OVF_W, 8, width of the saturating overflow counter.

Ports:
- Clock  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Din  in  WIDTH  sample from FIR (FIR Dout).
- Push  in  1  write strobe from FIR; one sample per high cycle.
- Dout  out  WIDTH  head-of-FIFO sample.
- Valid  out  1  Dout holds a valid sample.
- Ready  in  1  consumer accepts Dout this cycle.
- Level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- Full  out  1  Level == DEPTH.
- Empty  out  1  Level == 0.
- Overflow  out  1  sticky: a Push was dropped.
- OvfCount  out  OVF_W  number of dropped pushes, saturating.
- ClearOvf  in  1  clears Overflow and OvfCount.

Behaviour:
- Clock is Clock; reset is synchronous and active-high (Reset), sampled on the rising edge of Clock.
- Reset values: write/read pointers 0, Level 0, Valid 0, Empty 1, Full 0, Overflow 0, OvfCount 0, Dout 0. Storage contents are not reset.
- Reset mid-operation discards all buffered samples. Any Push in the reset cycle is ignored.
- Storage: DEPTH x WIDTH register array. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write: accepted when Push && (!Full || pop).
  - Din is stored at wr_ptr and wr_ptr increments.
- Pop: occurs when Valid && Ready; rd_ptr increments.
- Output is first-word-fall-through:
  - Dout = mem[rd_ptr] when !Empty, else 0.
  - Valid = !Empty.
- Latency: a Push in cycle n into an empty FIFO gives Valid=1 and Dout=Din in cycle n+1. There is no same-cycle bypass.
- Level update per cycle:
  - +1 on write only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Full and Empty are derived from the registered Level.
- Simultaneous push and pop when Full: the push is accepted with no overflow and Level stays DEPTH.
- Simultaneous push and pop when Empty: impossible, because Valid=0. The push is accepted and Level becomes 1.
- Overflow: a Push while Full with no pop in that cycle drops Din.
  - Overflow is set to 1.
  - OvfCount increments, saturating at 2^OVF_W-1.
  - FIFO contents and pointers are unchanged.
- ClearOvf: on the next edge, Overflow=0 and OvfCount=0.
  - If a drop occurs in the same cycle, the drop wins: Overflow=1, OvfCount=1.
- Ready while Empty has no effect; pointers do not move.
- Dout and Valid remain stable while Valid && !Ready. Sink stalls never corrupt the head.
- Push is not required to be a single-cycle pulse. Each high cycle is an independent write attempt.
- Flow-control constraint: the FIR pushes at most once per ~260 cycles, so back-to-back pushes occur only in test. The block supports one write per cycle regardless.

Test Plan:
- Reset, then Push Din=16'h1234 with Ready=0 -> next cycle Valid=1, Dout=16'h1234, Level=1, Empty=0; stays stable while Ready=0.
- Push 16'h0001..16'h0008 back-to-back, Ready=0 -> Full=1, Level=8. Then Ready=1 for 8 cycles -> Dout sequence 1..8, then Empty=1, Valid=0, Dout=0.
- With FIFO full, Push 16'hDEAD and 16'hBEEF with Ready=0 -> Overflow=1, OvfCount=2, Level=8. Drained order is unchanged: first pop yields 16'h0001.
- Full FIFO, Push 16'hCAFE with Ready=1 in the same cycle -> no overflow, Level stays 8, 16'hCAFE is popped last after the 7 remaining entries.
- Force 300 drops with OVF_W=8 -> OvfCount saturates at 255. Then ClearOvf coincident with another drop -> Overflow=1, OvfCount=1.
- Fill 5 entries, assert Reset for one cycle with Push=1 -> Level=0, Valid=0, Empty=1, Overflow=0. Next Push 16'h00AA appears at Dout one cycle later; pointer wrap is exercised by 20 push/pop pairs with data checked in order.

Source files
------------

// File: rtl/pcm_sample_fifo.sv
// pcm_sample_fifo
// ---------------
// Output buffer for the decimating FIR. Each cycle with Push high is one
// attempt to store Din; stored samples are handed to the consumer in order
// over a valid/ready handshake. The head of the queue is presented
// first-word-fall-through: Dout shows the oldest sample whenever Valid is
// high, and it changes only when that sample is popped.
//
// When the buffer is full and nothing leaves in the same cycle, the pushed
// sample is dropped. Overflow records that this has happened, and OvfCount
// counts the drops up to its maximum value. ClearOvf resets both.
//
// Ports
//   Clock     in   system clock; all state changes on the rising edge
//   Reset     in   synchronous, active-high reset
//   Din       in   [WIDTH]          sample from the FIR
//   Push      in   write attempt for Din this cycle
//   Dout      out  [WIDTH]          head-of-queue sample (0 when empty)
//   Valid     out  Dout holds a sample
//   Ready     in   consumer takes Dout this cycle
//   Level     out  [$clog2(DEPTH)+1] occupancy, 0..DEPTH
//   Full      out  Level == DEPTH
//   Empty     out  Level == 0
//   Overflow  out  sticky drop flag
//   OvfCount  out  [OVF_W]          saturating count of dropped pushes
//   ClearOvf  in   clears Overflow and OvfCount on the next edge
//
// DEPTH must be a power of two and at least 2, so that the pointers wrap
// from DEPTH-1 back to 0 without any explicit compare.

module pcm_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int OVF_W = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [WIDTH-1:0]           Din,
  input  logic                       Push,
  output logic [WIDTH-1:0]           Dout,
  output logic                       Valid,
  input  logic                       Ready,
  output logic [$clog2(DEPTH):0]     Level,
  output logic                       Full,
  output logic                       Empty,
  output logic                       Overflow,
  output logic [OVF_W-1:0]           OvfCount,
  input  logic                       ClearOvf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Sample storage. It is never reset; the pointers and the level alone
  // decide which entries are meaningful.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             overflow_q;
  logic [OVF_W-1:0] ovf_count_q;

  logic             is_full;
  logic             is_empty;
  logic             pop;
  logic             wr;
  logic             drop;
  logic             ovf_count_sat;

  // Status comes from the registered level only, so none of the outputs
  // below has a combinational path from any input.
  assign is_full  = (level_q == LVL_W'(DEPTH));
  assign is_empty = (level_q == '0);

  // Pop needs Valid, so Ready on an empty buffer moves nothing.
  assign pop  = !is_empty && Ready;

  // A full buffer still accepts a push when the head leaves in the same
  // cycle: the freed slot is reused immediately and the level holds.
  assign wr   = Push && (!is_full || pop);
  assign drop = Push && is_full && !pop;

  assign ovf_count_sat = &ovf_count_q;

  // Storage write. It is gated by Reset so that a Push arriving in the
  // reset cycle leaves no trace, even in the unreset array.
  always_ff @(posedge Clock) begin
    if (!Reset && wr) begin
      mem[wr_ptr] <= Din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({wr, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Drop tracking. A drop in the same cycle as ClearOvf wins: the clear
  // wipes the old history, and the new drop is the first one counted
  // afterwards.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      overflow_q  <= 1'b0;
      ovf_count_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (ClearOvf) begin
        ovf_count_q <= OVF_W'(1);
      end else if (!ovf_count_sat) begin
        ovf_count_q <= ovf_count_q + OVF_W'(1);
      end
    end else if (ClearOvf) begin
      overflow_q  <= 1'b0;
      ovf_count_q <= '0;
    end
  end

  // First-word-fall-through head. It is forced to zero while empty, so a
  // stale storage entry is never shown with Valid low.
  assign Dout     = is_empty ? '0 : mem[rd_ptr];
  assign Valid    = !is_empty;
  assign Level    = level_q;
  assign Full     = is_full;
  assign Empty    = is_empty;
  assign Overflow = overflow_q;
  assign OvfCount = ovf_count_q;

endmodule

// File: tb/tb_pcm_sample_fifo.sv
module tb_pcm_sample_fifo;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 8;
  localparam int OVF_W   = 8;
  localparam int OVF_MAX = (1 << OVF_W) - 1;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic [WIDTH-1:0] Din = '0;
  logic             Push = 1'b0;
  logic [WIDTH-1:0] Dout;
  logic             Valid;
  logic             Ready = 1'b0;
  logic [3:0]       Level;
  logic             Full;
  logic             Empty;
  logic             Overflow;
  logic [OVF_W-1:0] OvfCount;
  logic             ClearOvf = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  pcm_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVF_W(OVF_W)) dut (
    .Clock(Clock), .Reset(Reset), .Din(Din), .Push(Push), .Dout(Dout),
    .Valid(Valid), .Ready(Ready), .Level(Level), .Full(Full), .Empty(Empty),
    .Overflow(Overflow), .OvfCount(OvfCount), .ClearOvf(ClearOvf)
  );

  always #5 Clock = ~Clock;

  // Reference model: a plain queue of buffered samples plus drop history.
  logic [WIDTH-1:0] q[$];
  bit               m_ovf;
  int               m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit push, input logic [WIDTH-1:0] din,
                            input bit ready, input bit clr);
    bit full, pop, drop;
    if (rst) begin
      q.delete();
      m_ovf = 0;
      m_cnt = 0;
      return;
    end
    full = (q.size() == DEPTH);
    pop  = (q.size() > 0) && ready;
    drop = push && full && !pop;
    if (pop) void'(q.pop_front());
    if (push && !drop) q.push_back(din);
    if (drop) begin
      m_ovf = 1;
      m_cnt = clr ? 1 : ((m_cnt == OVF_MAX) ? OVF_MAX : m_cnt + 1);
    end else if (clr) begin
      m_ovf = 0;
      m_cnt = 0;
    end
  endtask

  task automatic check_model();
    check("valid",    32'(Valid),    32'(q.size() > 0));
    check("dout",     32'(Dout),     (q.size() > 0) ? 32'(q[0]) : 32'h0);
    check("level",    32'(Level),    32'(q.size()));
    check("full",     32'(Full),     32'(q.size() == DEPTH));
    check("empty",    32'(Empty),    32'(q.size() == 0));
    check("overflow", 32'(Overflow), 32'(m_ovf));
    check("ovfcount", 32'(OvfCount), 32'(m_cnt));
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later, compare.
  task automatic step(input bit rst, input bit push, input logic [WIDTH-1:0] din,
                      input bit ready, input bit clr);
    Reset = rst; Push = push; Din = din; Ready = ready; ClearOvf = clr;
    @(posedge Clock);
    #1;
    model_step(rst, push, din, ready, clr);
    check_model();
  endtask

  typedef struct {
    bit               rst;
    bit               push;
    logic [WIDTH-1:0] din;
    bit               ready;
    bit               clr;
    bit               e_valid;
    logic [WIDTH-1:0] e_dout;
    int               e_level;
    bit               e_full;
    bit               e_empty;
    bit               e_ovf;
    int               e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit push, logic [WIDTH-1:0] din, bit ready, bit clr,
                              bit ev, logic [WIDTH-1:0] ed, int el, bit ef, bit ee,
                              bit eo, int ec);
    vec_t v;
    v.rst = rst; v.push = push; v.din = din; v.ready = ready; v.clr = clr;
    v.e_valid = ev; v.e_dout = ed; v.e_level = el; v.e_full = ef; v.e_empty = ee;
    v.e_ovf = eo; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    // Directed vectors: rst push din ready clr | valid dout level full empty ovf cnt
    vecs.push_back(mk(1, 1, 16'h5555, 0, 0,  0, 16'h0000, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 16'h1234, 0, 0,  1, 16'h1234, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 16'h1234, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0,  1, 16'h1234, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0,  0, 16'h0000, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0,  0, 16'h0000, 0, 0, 1, 0, 0));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(0, 1, 16'(i), 0, 0, 1, 16'h0001, i, (i == 8), 0, 0, 0));
    vecs.push_back(mk(0, 1, 16'hDEAD, 0, 0,  1, 16'h0001, 8, 1, 0, 1, 1));
    vecs.push_back(mk(0, 1, 16'hBEEF, 0, 0,  1, 16'h0001, 8, 1, 0, 1, 2));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0,  1, 16'h0002, 7, 0, 0, 1, 2));
    for (int i = 3; i <= 9; i++)
      vecs.push_back(mk(0, 0, 16'h0000, 1, 0, (i <= 8), (i <= 8) ? 16'(i) : 16'h0,
                        9 - i, 0, (i == 9), 1, 2));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1,  0, 16'h0000, 0, 0, 1, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].push, vecs[i].din, vecs[i].ready, vecs[i].clr);
      check("tbl_valid", 32'(Valid),    32'(vecs[i].e_valid));
      check("tbl_dout",  32'(Dout),     32'(vecs[i].e_dout));
      check("tbl_level", 32'(Level),    32'(vecs[i].e_level));
      check("tbl_full",  32'(Full),     32'(vecs[i].e_full));
      check("tbl_empty", 32'(Empty),    32'(vecs[i].e_empty));
      check("tbl_ovf",   32'(Overflow), 32'(vecs[i].e_ovf));
      check("tbl_cnt",   32'(OvfCount), 32'(vecs[i].e_cnt));
    end

    // Full buffer, push with simultaneous pop: accepted, no overflow.
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) step(0, 1, 16'(i), 0, 0);
    step(0, 1, 16'hCAFE, 1, 0);
    check("cafe_level", 32'(Level), 32'd8);
    check("cafe_ovf",   32'(Overflow), 32'd0);
    check("cafe_head",  32'(Dout), 32'h2);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0);
    check("cafe_last", 32'(Dout), 32'hCAFE);
    step(0, 0, 0, 1, 0);
    check("cafe_empty", 32'(Empty), 32'd1);

    // Saturation, then clear coincident with a drop.
    for (int i = 1; i <= 8; i++) step(0, 1, 16'(i + 16'h100), 0, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 16'(i), 0, 0);
    check("sat_cnt", 32'(OvfCount), 32'(OVF_MAX));
    step(0, 1, 16'h7777, 0, 1);
    check("clr_drop_ovf", 32'(Overflow), 32'd1);
    check("clr_drop_cnt", 32'(OvfCount), 32'd1);
    step(0, 0, 0, 0, 1);
    check("clr_cnt", 32'(OvfCount), 32'd0);
    check("clr_ovf", 32'(Overflow), 32'd0);

    // Reset mid-operation with Push high, then wrap via push/pop pairs.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 16'(i + 16'h40), 0, 0);
    step(0, 1, 16'h9999, 0, 0);   // 6th entry, leaves head at 0x40
    step(1, 1, 16'hBBBB, 0, 0);
    check("rst_level", 32'(Level), 32'd0);
    check("rst_valid", 32'(Valid), 32'd0);
    check("rst_empty", 32'(Empty), 32'd1);
    check("rst_ovf",   32'(Overflow), 32'd0);
    step(0, 1, 16'h00AA, 0, 0);
    check("post_rst_dout", 32'(Dout), 32'h00AA);
    for (int i = 0; i < 20; i++) step(0, 1, 16'(16'h0500 + i), 1, 0);
    check("wrap_head", 32'(Dout), 32'h0513);
    check("wrap_level", 32'(Level), 32'd1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 99) < 55),
           16'($urandom),
           ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 49) == 0));
    end

    Reset = 0; Push = 0; Ready = 0; ClearOvf = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
